// File: rtl/slot_alloc_flags.sv
// slot_alloc_flags: 16-slot lowest-free allocator with registered busy flags, occupancy, full/empty.
// Define SLOT_ALLOC_ERR_EN to add the sticky err output for idle-slot frees and requests while full.
module slot_alloc_flags (
  input  logic        clk,
  input  logic        rst,
  input  logic        alloc_req,
  output logic        alloc_gnt,
  output logic [3:0]  alloc_idx,
  input  logic        free_vld,
  input  logic [3:0]  free_idx,
  output logic [15:0] busy_mask,
  output logic [4:0]  occupancy,
  output logic        full,
  output logic        empty
`ifdef SLOT_ALLOC_ERR_EN
  ,output logic       err
`endif
);
  logic [15:0] r_busy;
  logic [4:0]  r_occ;
  logic        r_full, r_empty;
  logic [3:0]  w_idx;
  logic        w_hit;
  logic [15:0] w_busy_nxt;
  logic [4:0]  w_occ_nxt;
  always_comb begin
    w_idx = 4'd0;
    for (int i = 15; i >= 0; i--) if (!r_busy[i]) w_idx = 4'(i);
  end
  assign alloc_gnt  = alloc_req & ~r_full & ~rst;
  assign alloc_idx  = alloc_gnt ? w_idx : 4'd0;
  // a free only counts when its slot is busy, so it can never collide with the grant
  assign w_hit      = free_vld & r_busy[free_idx];
  assign w_busy_nxt = (r_busy & ~(w_hit ? 16'd1 << free_idx : 16'd0)) | (alloc_gnt ? 16'd1 << w_idx : 16'd0);
  assign w_occ_nxt  = r_occ + {4'd0, alloc_gnt} - {4'd0, w_hit};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_busy  <= '0;
      r_occ   <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      r_busy  <= w_busy_nxt;
      r_occ   <= w_occ_nxt;
      r_full  <= w_occ_nxt == 5'd16;
      r_empty <= w_occ_nxt == 5'd0;
    end
  assign busy_mask = r_busy;
  assign occupancy = r_occ;
  assign full      = r_full;
  assign empty     = r_empty;
`ifdef SLOT_ALLOC_ERR_EN
  logic r_err;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_err <= 1'b0;
    else     r_err <= r_err | (free_vld & ~r_busy[free_idx]) | (alloc_req & r_full);
  assign err = r_err;
`endif
endmodule

// File: tb/tb_slot_alloc_flags.sv
// tb_slot_alloc_flags: scoreboard bench for slot_alloc_flags against a behavioural slot model.
module tb_slot_alloc_flags;
  logic        clk = 1'b0;
  logic        rst, alloc_req, free_vld;
  logic [3:0]  free_idx;
  logic        alloc_gnt;
  logic [3:0]  alloc_idx;
  logic [15:0] busy_mask;
  logic [4:0]  occupancy;
  logic        full, empty;
`ifdef SLOT_ALLOC_ERR_EN
  logic        err;
  logic        m_err;
`endif
  typedef struct {logic gnt; logic [3:0] idx;} exp_t;
  exp_t        q[$];
  exp_t        e;
  logic [15:0] m_busy;
  logic        p_gnt;
  logic [3:0]  p_idx;
  int          n_vec = 0, n_err = 0;

  slot_alloc_flags dut (
    .clk(clk), .rst(rst), .alloc_req(alloc_req), .alloc_gnt(alloc_gnt), .alloc_idx(alloc_idx),
    .free_vld(free_vld), .free_idx(free_idx), .busy_mask(busy_mask), .occupancy(occupancy),
    .full(full), .empty(empty)
`ifdef SLOT_ALLOC_ERR_EN
    ,.err(err)
`endif
  );

  always #5 clk = ~clk;

  task automatic apply(input logic req, input logic fv, input logic [3:0] fi);
    exp_t x;
    x.gnt = req && (m_busy != 16'hFFFF);
    x.idx = 4'd0;
    if (x.gnt)
      for (int i = 0; i < 16; i++)
        if (!m_busy[i]) begin x.idx = 4'(i); break; end
    alloc_req = req; free_vld = fv; free_idx = fi;
    p_gnt = x.gnt; p_idx = x.idx;
    q.push_back(x);
  endtask

  task automatic tick;
    logic [15:0] nb;
    nb = m_busy;
    if (free_vld && m_busy[free_idx]) nb[free_idx] = 1'b0;
`ifdef SLOT_ALLOC_ERR_EN
    if (free_vld && !m_busy[free_idx]) m_err = 1'b1;
    if (alloc_req && m_busy == 16'hFFFF) m_err = 1'b1;
`endif
    if (p_gnt) nb[p_idx] = 1'b1;
    @(posedge clk); #1;
    m_busy = nb;
    alloc_req = 1'b0; free_vld = 1'b0;
  endtask

  task automatic do_reset;
    rst = 1'b1; alloc_req = 1'b0; free_vld = 1'b0; free_idx = 4'd0;
    m_busy = '0;
`ifdef SLOT_ALLOC_ERR_EN
    m_err = 1'b0;
`endif
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic pop_cmp(input string nm);
    e = q.pop_front();
    n_vec++; if (alloc_gnt !== e.gnt) begin n_err++; $display("FAIL %s_gnt got %0b want %0b", nm, alloc_gnt, e.gnt); end
    n_vec++; if (alloc_idx !== e.idx) begin n_err++; $display("FAIL %s_idx got %0d want %0d", nm, alloc_idx, e.idx); end
  endtask

  task automatic test_reset;
    rst = 1'b1; alloc_req = 1'b1; free_vld = 1'b1; free_idx = 4'd3;
    m_busy = '0;
`ifdef SLOT_ALLOC_ERR_EN
    m_err = 1'b0;
`endif
    repeat (2) @(posedge clk); #1;
    n_vec++; if (busy_mask !== 16'h0) begin n_err++; $display("FAIL rst_mask got %h want 0000", busy_mask); end
    n_vec++; if (occupancy !== 5'd0) begin n_err++; $display("FAIL rst_occ got %0d want 0", occupancy); end
    n_vec++; if (full !== 1'b0) begin n_err++; $display("FAIL rst_full got %0b want 0", full); end
    n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL rst_empty got %0b want 1", empty); end
    n_vec++; if (alloc_gnt !== 1'b0) begin n_err++; $display("FAIL rst_gnt got %0b want 0", alloc_gnt); end
`ifdef SLOT_ALLOC_ERR_EN
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL rst_err got %0b want 0", err); end
`endif
    alloc_req = 1'b0; free_vld = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_fill;
    for (int i = 0; i < 16; i++) begin
      apply(1'b1, 1'b0, 4'd0);
      #1;
      pop_cmp("fill");
      n_vec++; if (alloc_idx !== 4'(i)) begin n_err++; $display("FAIL fill_order got %0d want %0d", alloc_idx, i); end
      tick();
    end
    n_vec++; if (busy_mask !== 16'hFFFF) begin n_err++; $display("FAIL fill_mask got %h want ffff", busy_mask); end
    n_vec++; if (occupancy !== 5'd16) begin n_err++; $display("FAIL fill_occ got %0d want 16", occupancy); end
    n_vec++; if (full !== 1'b1) begin n_err++; $display("FAIL fill_full got %0b want 1", full); end
    n_vec++; if (empty !== 1'b0) begin n_err++; $display("FAIL fill_empty got %0b want 0", empty); end
  endtask

  task automatic test_full_free;
    apply(1'b1, 1'b1, 4'd5);
    #1;
    pop_cmp("ffree");
    n_vec++; if (alloc_gnt !== 1'b0) begin n_err++; $display("FAIL ffree_nogrant got %0b want 0", alloc_gnt); end
    tick();
    n_vec++; if (busy_mask !== 16'hFFDF) begin n_err++; $display("FAIL ffree_mask got %h want ffdf", busy_mask); end
    n_vec++; if (occupancy !== 5'd15) begin n_err++; $display("FAIL ffree_occ got %0d want 15", occupancy); end
    n_vec++; if (full !== 1'b0) begin n_err++; $display("FAIL ffree_full got %0b want 0", full); end
`ifdef SLOT_ALLOC_ERR_EN
    n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL ffree_err got %0b want 1", err); end
`endif
    apply(1'b1, 1'b0, 4'd0);
    #1;
    pop_cmp("refill");
    n_vec++; if (alloc_idx !== 4'd5) begin n_err++; $display("FAIL refill_idx got %0d want 5", alloc_idx); end
    tick();
    n_vec++; if (full !== 1'b1) begin n_err++; $display("FAIL refill_full got %0b want 1", full); end
  endtask

  task automatic test_simul;
    do_reset();
    for (int i = 0; i < 4; i++) begin apply(1'b1, 1'b0, 4'd0); #1; pop_cmp("sim_pre"); tick(); end
    n_vec++; if (busy_mask !== 16'h000F) begin n_err++; $display("FAIL sim_pre_mask got %h want 000f", busy_mask); end
    apply(1'b1, 1'b1, 4'd1);
    #1;
    pop_cmp("sim");
    n_vec++; if (alloc_idx !== 4'd4) begin n_err++; $display("FAIL sim_idx got %0d want 4", alloc_idx); end
    tick();
    n_vec++; if (busy_mask !== 16'h001D) begin n_err++; $display("FAIL sim_mask got %h want 001d", busy_mask); end
    n_vec++; if (occupancy !== 5'd4) begin n_err++; $display("FAIL sim_occ got %0d want 4", occupancy); end
    apply(1'b1, 1'b0, 4'd0);
    #1;
    pop_cmp("sim_next");
    n_vec++; if (alloc_idx !== 4'd1) begin n_err++; $display("FAIL sim_next_idx got %0d want 1", alloc_idx); end
    tick();
  endtask

  task automatic test_idle_free;
    do_reset();
    apply(1'b0, 1'b1, 4'd7);
    #1;
    pop_cmp("idle");
    tick();
    n_vec++; if (busy_mask !== 16'h0) begin n_err++; $display("FAIL idle_mask got %h want 0000", busy_mask); end
    n_vec++; if (occupancy !== 5'd0) begin n_err++; $display("FAIL idle_occ got %0d want 0", occupancy); end
    n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL idle_empty got %0b want 1", empty); end
`ifdef SLOT_ALLOC_ERR_EN
    n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL idle_err got %0b want 1", err); end
    apply(1'b0, 1'b0, 4'd0); #1; pop_cmp("idle_hold"); tick();
    n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL idle_err_sticky got %0b want 1", err); end
`endif
  endtask

  task automatic test_async_reset;
    do_reset();
    for (int i = 0; i < 9; i++) begin apply(1'b1, 1'b0, 4'd0); #1; pop_cmp("ar_pre"); tick(); end
    n_vec++; if (occupancy !== 5'd9) begin n_err++; $display("FAIL ar_occ9 got %0d want 9", occupancy); end
    #2;
    alloc_req = 1'b1;
    rst = 1'b1;
    #1;
    n_vec++; if (busy_mask !== 16'h0) begin n_err++; $display("FAIL ar_mask got %h want 0000", busy_mask); end
    n_vec++; if (occupancy !== 5'd0) begin n_err++; $display("FAIL ar_occ got %0d want 0", occupancy); end
    n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL ar_empty got %0b want 1", empty); end
    n_vec++; if (alloc_gnt !== 1'b0) begin n_err++; $display("FAIL ar_gnt got %0b want 0", alloc_gnt); end
    m_busy = '0;
`ifdef SLOT_ALLOC_ERR_EN
    m_err = 1'b0;
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    apply(1'b1, 1'b0, 4'd0);
    #1;
    pop_cmp("ar_post");
    n_vec++; if (alloc_idx !== 4'd0) begin n_err++; $display("FAIL ar_post_idx got %0d want 0", alloc_idx); end
    tick();
  endtask

  task automatic test_back_to_back;
    do_reset();
    for (int c = 0; c < 300; c++) begin
      apply(1'($urandom_range(3, 0) != 0), 1'($urandom_range(1, 0)), 4'($urandom_range(15, 0)));
      #1;
      pop_cmp("b2b");
      tick();
      n_vec++; if (busy_mask !== m_busy) begin n_err++; $display("FAIL b2b_mask got %h want %h", busy_mask, m_busy); end
      n_vec++; if (occupancy !== 5'($countones(m_busy))) begin n_err++; $display("FAIL b2b_occ got %0d want %0d", occupancy, $countones(m_busy)); end
      n_vec++; if (full !== (m_busy == 16'hFFFF)) begin n_err++; $display("FAIL b2b_full got %0b", full); end
      n_vec++; if (empty !== (m_busy == 16'h0)) begin n_err++; $display("FAIL b2b_empty got %0b", empty); end
`ifdef SLOT_ALLOC_ERR_EN
      n_vec++; if (err !== m_err) begin n_err++; $display("FAIL b2b_err got %0b want %0b", err, m_err); end
`endif
    end
  endtask

  initial begin
    p_gnt = 1'b0; p_idx = 4'd0;
    #1;
    test_reset();
    test_fill();
    test_full_free();
    test_simul();
    test_idle_free();
    test_async_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/slot_alloc_flags.md
SLOT_ALLOC_FLAGS -- requirements
Module: slot_alloc_flags

Interface
REQ-001: The block SHALL have no parameters; slot count is fixed at 16, slot index width at 4.
REQ-002: clk  input  1  clock; all state updates on the rising edge.
REQ-003: rst  input  1  reset; asynchronous, active-high.
REQ-004: alloc_req  input  1  request to allocate one free slot this cycle.
REQ-005: alloc_gnt  output  1  request accepted this cycle; combinational from alloc_req and registered state.
REQ-006: alloc_idx  output  4  slot granted; valid only while alloc_gnt=1, otherwise 0.
REQ-007: free_vld  input  1  release of slot free_idx this cycle.
REQ-008: free_idx  input  4  slot to release.
REQ-009: busy_mask  output  16  registered per-slot busy flags; bit i = slot i allocated.
REQ-010: occupancy  output  5  registered count of busy slots, 0..16.
REQ-011: full  output  1  registered; 1 when occupancy=16.
REQ-012: empty  output  1  registered; 1 when occupancy=0.
REQ-013: err  output  1  sticky protocol-error flag; present only under SLOT_ALLOC_ERR_EN.

Function
REQ-014: Each busy flag SHALL behave as a set/enable/reset flop: set by a grant, cleared by a valid free, held otherwise.
REQ-015: alloc_gnt SHALL be 1 exactly when alloc_req=1 and full=0.
REQ-016: alloc_idx SHALL be the lowest-numbered slot with busy_mask bit 0, computed from the registered mask.
REQ-017: The granted slot's busy bit SHALL read 1 on the edge following the grant (latency 1).
REQ-018: A valid free of a busy slot SHALL clear that bit on the next edge.
REQ-019: A free of an already-idle slot SHALL leave all state unchanged.
REQ-020: Simultaneous grant and free in one cycle SHALL apply both; a slot freed this cycle is not grantable until the next cycle.
REQ-021: Grant while full=1 SHALL NOT occur; a free in that cycle still applies, so full deasserts next edge.
REQ-022: occupancy SHALL update by +1 (grant only), -1 (effective free only), or 0 (both, or neither), and SHALL always equal popcount(busy_mask).
REQ-023: full and empty SHALL be registered alongside occupancy, never decoded combinationally from inputs.
REQ-024: Occupancy SHALL never wrap: no increment at 16, no decrement at 0.

Reset
REQ-025: Asserting rst SHALL immediately force busy_mask=0, occupancy=0, full=0, empty=1, err=0, regardless of clk.
REQ-026: While rst=1, alloc_gnt SHALL be 0 and no input SHALL change state.
REQ-027: Reset mid-operation SHALL discard all allocations; the first grant after release is slot 0.

Configuration
REQ-028: Macro SLOT_ALLOC_ERR_EN SHALL gate protocol-error detection.
REQ-029: With SLOT_ALLOC_ERR_EN defined, err SHALL set on the edge after any free of an idle slot, or after alloc_req while full=1, and hold until rst.
REQ-030: Without SLOT_ALLOC_ERR_EN, err and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-031: Reset, then alloc_req=1 for 16 cycles -> alloc_idx 0,1,...,15 in order; after the last edge busy_mask=16'hFFFF, occupancy=16, full=1.
REQ-032: full, alloc_req=1 and free_vld=1 with free_idx=5 in the same cycle -> alloc_gnt=0; next cycle bit 5=0, occupancy=15, alloc_idx=5 on re-request.
REQ-033: busy_mask=16'h000F, alloc_req=1 and free of slot 1 in the same cycle -> alloc_idx=4; next busy_mask=16'h001D, occupancy=4 unchanged.
REQ-034: empty, free_vld=1 with free_idx=7 -> state unchanged; err=1 next cycle with the macro, no err port without it.
REQ-035: occupancy=9, assert rst between clock edges -> outputs clear immediately; after release alloc_idx=0.
